// File: rtl/systolic_array_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: clears the accumulators,
// streams K skewed A/B vectors from single-port buffers, drains, then pulses done.
module systolic_array_ctrl #(
    parameter int N      = 8,
    parameter int DATA_W = 8,
    parameter int K_MAX  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    output logic                       busy,
    output logic                       done,
    output logic                       a_rd_en,
    output logic [$clog2(K_MAX)-1:0]   a_rd_addr,
    input  logic [N*DATA_W-1:0]        a_rd_data,
    output logic                       b_rd_en,
    output logic [$clog2(K_MAX)-1:0]   b_rd_addr,
    input  logic [N*DATA_W-1:0]        b_rd_data,
    output logic                       arr_clr,
    output logic [N*DATA_W-1:0]        arr_a_in,
    output logic [N*DATA_W-1:0]        arr_b_in
);

    localparam int KW = $clog2(K_MAX+1);
    localparam int AW = $clog2(K_MAX);
    localparam int DW = $clog2(2*N);
    localparam logic [KW-1:0] K_MAX_V    = KW'(K_MAX);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(2*N-1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t              state, state_nx;
    logic [KW-1:0]       k_q;
    logic [AW-1:0]       f_q;
    logic [DW-1:0]       d_q;
    logic                rd_vld_q;
    logic [N*DATA_W-1:0] a_cap, b_cap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        a_rd_en  = 1'b0;
        arr_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                busy     = 1'b1;
                arr_clr  = 1'b1;
                state_nx = (k_q == '0) ? DONE : FEED;
            end
            FEED: begin
                busy    = 1'b1;
                a_rd_en = 1'b1;
                if (KW'(f_q) == k_q - KW'(1)) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (d_q == DRAIN_LAST) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // f_q returns to 0 as FEED ends, so the address needs no extra gating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q      <= '0;
            f_q      <= '0;
            d_q      <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= a_rd_en;
            if (state == IDLE && start) k_q <= (k_len > K_MAX_V) ? K_MAX_V : k_len;
            f_q <= (state == FEED && state_nx == FEED) ? f_q + AW'(1) : '0;
            d_q <= (state == DRAIN) ? d_q + DW'(1) : '0;
        end
    end

    assign b_rd_en   = a_rd_en;
    assign a_rd_addr = f_q;
    assign b_rd_addr = f_q;

    assign a_cap = rd_vld_q ? a_rd_data : '0;
    assign b_cap = rd_vld_q ? b_rd_data : '0;

    assign arr_a_in[DATA_W-1:0] = a_cap[DATA_W-1:0];
    assign arr_b_in[DATA_W-1:0] = b_cap[DATA_W-1:0];

    // Lane g is delayed by g registers; zeros shift in when no read data is valid.
    for (genvar g = 1; g < N; g++) begin : g_skew
        logic [DATA_W-1:0] a_dl [g];
        logic [DATA_W-1:0] b_dl [g];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int unsigned s = 0; s < g; s++) begin
                    a_dl[s] <= '0;
                    b_dl[s] <= '0;
                end
            end else if (arr_clr) begin
                for (int unsigned s = 0; s < g; s++) begin
                    a_dl[s] <= '0;
                    b_dl[s] <= '0;
                end
            end else begin
                a_dl[0] <= a_cap[g*DATA_W +: DATA_W];
                b_dl[0] <= b_cap[g*DATA_W +: DATA_W];
                for (int unsigned s = 1; s < g; s++) begin
                    a_dl[s] <= a_dl[s-1];
                    b_dl[s] <= b_dl[s-1];
                end
            end
        end

        assign arr_a_in[g*DATA_W +: DATA_W] = a_dl[g-1];
        assign arr_b_in[g*DATA_W +: DATA_W] = b_dl[g-1];
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: buffer models, a behavioural output-stationary
// array, and a per-run scoreboard of expected C, read count and latency.
module tb_systolic_array_ctrl;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int K_MAX  = 4;
    localparam int KW     = $clog2(K_MAX+1);
    localparam int AW     = $clog2(K_MAX);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [KW-1:0]       k_len = '0;
    logic                busy, done, a_rd_en, b_rd_en, arr_clr;
    logic [AW-1:0]       a_rd_addr, b_rd_addr;
    logic [N*DATA_W-1:0] a_rd_data = '0;
    logic [N*DATA_W-1:0] b_rd_data = '0;
    logic [N*DATA_W-1:0] arr_a_in, arr_b_in;

    systolic_array_ctrl #(.N(N), .DATA_W(DATA_W), .K_MAX(K_MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .arr_clr(arr_clr), .arr_a_in(arr_a_in), .arr_b_in(arr_b_in)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // A[i][k] and B[k][j] buffer contents; single-cycle registered reads
    logic [7:0] a_mat [N][K_MAX];
    logic [7:0] b_mat [K_MAX][N];

    always @(posedge clk) begin
        if (a_rd_en) for (int i = 0; i < N; i++) a_rd_data[i*8 +: 8] <= a_mat[i][a_rd_addr];
        if (b_rd_en) for (int j = 0; j < N; j++) b_rd_data[j*8 +: 8] <= b_mat[b_rd_addr][j];
    end

    task automatic set_pattern(input int pat);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K_MAX; k++)
                case (pat)
                    0:       a_mat[i][k] = (i == k) ? 8'd1 : 8'd0;
                    1:       a_mat[i][k] = 8'd2;
                    default: a_mat[i][k] = 8'($urandom_range(0, 15));
                endcase
        for (int k = 0; k < K_MAX; k++)
            for (int j = 0; j < N; j++)
                case (pat)
                    0:       b_mat[k][j] = 8'(4*k + j + 1);
                    1:       b_mat[k][j] = 8'd3;
                    default: b_mat[k][j] = 8'($urandom_range(0, 15));
                endcase
    endtask

    typedef struct packed {
        logic [7:0]          k;
        logic [7:0]          reads;
        logic [7:0]          lat;
        logic [N*N*16-1:0]   c;
    } rec_t;

    rec_t sb[$];
    rec_t cur;

    task automatic push_run(input int kl, input int reads, input int lat);
        rec_t r;
        int   ke, s;
        ke = (kl > K_MAX) ? K_MAX : kl;
        r.k = 8'(ke);
        r.reads = 8'(reads);
        r.lat = 8'(lat);
        r.c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < ke; k++) s += int'(a_mat[i][k]) * int'(b_mat[k][j]);
                r.c[(i*N+j)*16 +: 16] = 16'(s);
            end
        sb.push_back(r);
    endtask

    // Monitor: behavioural array plus per-cycle expectations for the active run
    int  cyc = 0, clr_cyc = 0, reads = 0, done_count = 0;
    int  last_done_cyc = -100, last_clr_cyc = -100;
    bit  in_run = 1'b0;

    int  acc [N][N];
    int  ar  [N][N];
    int  br  [N][N];

    always @(negedge clk) begin : monitor
        int                  t, done_t, k, ta, tb;
        int                  na [N][N];
        int                  nb [N][N];
        logic                e_busy, e_done, e_clr, e_en;
        int                  e_addr;
        logic [AW+5:0]       act_ctl, exp_ctl;
        logic [N*DATA_W-1:0] ea, eb;
        logic [N*N*16-1:0]   c_flat;

        cyc++;
        if (!rst) begin
            in_run = 1'b0;
        end else begin
            if (arr_clr) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        acc[i][j] = 0; ar[i][j] = 0; br[i][j] = 0;
                    end
            end else begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        na[i][j] = (j == 0) ? int'(arr_a_in[i*8 +: 8]) : ar[i][j-1];
                        nb[i][j] = (i == 0) ? int'(arr_b_in[j*8 +: 8]) : br[i-1][j];
                    end
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        acc[i][j] += na[i][j] * nb[i][j];
                        ar[i][j] = na[i][j];
                        br[i][j] = nb[i][j];
                    end
            end

            if (arr_clr && !in_run) begin
                check($sformatf("clear_has_request cyc%0d", cyc), 256'(sb.size() != 0), 256'(1));
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    in_run = 1'b1;
                    clr_cyc = cyc;
                    last_clr_cyc = cyc;
                    reads = 0;
                end
            end

            e_busy = 1'b0; e_done = 1'b0; e_clr = 1'b0; e_en = 1'b0; e_addr = 0;
            ea = '0; eb = '0; t = 0; done_t = 0;
            if (in_run) begin
                k = int'(cur.k);
                t = cyc - clr_cyc - 1;
                done_t = (k == 0) ? 0 : k + 2*N;
                e_clr  = (t == -1);
                e_busy = (t < done_t);
                e_done = (t == done_t);
                e_en   = (t >= 0) && (t < k);
                e_addr = e_en ? t : 0;
                for (int i = 0; i < N; i++) begin
                    ta = t - 1 - i;
                    if (ta >= 0 && ta < k) ea[i*8 +: 8] = a_mat[i][ta];
                    tb = t - 1 - i;
                    if (tb >= 0 && tb < k) eb[i*8 +: 8] = b_mat[tb][i];
                end
            end
            act_ctl = {busy, done, arr_clr, a_rd_en, (a_rd_en ? a_rd_addr : AW'(0)),
                       (b_rd_en == a_rd_en), (b_rd_addr == a_rd_addr)};
            exp_ctl = {e_busy, e_done, e_clr, e_en, AW'(e_addr), 2'b11};
            check($sformatf("ctl cyc%0d", cyc), 256'(act_ctl), 256'(exp_ctl));
            check($sformatf("lanes cyc%0d", cyc), 256'({arr_b_in, arr_a_in}), 256'({eb, ea}));

            if (in_run && a_rd_en) reads++;
            if (in_run && (done || t >= done_t + 4)) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) c_flat[(i*N+j)*16 +: 16] = 16'(acc[i][j]);
                check("run_reads_latency", 256'({8'(reads), 8'(cyc - clr_cyc)}),
                      256'({cur.reads, cur.lat}));
                check("matrix_c", 256'(c_flat), 256'(cur.c));
                in_run = 1'b0;
                done_count++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic wait_done(input int target);
        int c = 0;
        while (done_count < target && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("done_within_budget", 256'(done_count >= target), 256'(1));
    endtask

    typedef struct {
        int k_len;
        int pat;
        int reads;
        int lat;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : driver
        int tgt, d1;
        vecs[0] = '{4, 0, 4, 13};
        vecs[1] = '{4, 1, 4, 13};
        vecs[2] = '{0, 2, 0, 1};
        vecs[3] = '{7, 2, 4, 13};
        vecs[4] = '{2, 2, 2, 11};
        vecs[5] = '{1, 1, 1, 10};
        vecs[6] = '{3, 0, 3, 12};

        set_pattern(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 256'({busy, done, a_rd_en, b_rd_en, arr_clr, a_rd_addr, b_rd_addr,
                                     arr_a_in, arr_b_in}), '0);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[v]) begin
            set_pattern(vecs[v].pat);
            push_run(vecs[v].k_len, vecs[v].reads, vecs[v].lat);
            tgt = done_count + 1;
            k_len = KW'(vecs[v].k_len);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            k_len = KW'($urandom_range(0, 7));
            wait_done(tgt);
            @(posedge clk); #1;
        end

        // start pulses in FEED and in DONE must be ignored
        set_pattern(2);
        push_run(4, 4, 13);
        tgt = done_count + 1;
        k_len = KW'(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("single_done_with_extra_starts", 256'(done_count), 256'(tgt));

        // start held high across two runs re-triggers right after DONE
        set_pattern(2);
        push_run(3, 3, 12);
        push_run(3, 3, 12);
        tgt = done_count + 1;
        k_len = KW'(3);
        start = 1'b1;
        wait_done(tgt);
        d1 = last_done_cyc;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(tgt + 1);
        check("b2b_clear_after_idle", 256'(last_clr_cyc - d1), 256'(2));
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset in the second FEED cycle aborts without done
        set_pattern(1);
        push_run(4, 4, 13);
        tgt = done_count;
        k_len = KW'(4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_async_outputs", 256'({busy, done, a_rd_en, b_rd_en, arr_clr, arr_a_in, arr_b_in}), '0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_abort", 256'(done_count), 256'(tgt));

        set_pattern(2);
        push_run(4, 4, 13);
        tgt = done_count + 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tgt);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 256'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
